viterbi_frame_ctrl: RTL

//  Frame sequencer for the Viterbi decoder. Accepts FRAME_LEN received symbols and strobes the path

---
 rtl/viterbi_frame_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi decoder: symbol intake, survivor writes,
// best-state selection and traceback stream (newest traced state first).
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  input  logic              sym_valid_i,
  output logic              sym_ready_o,
  output logic              path_enable_o,
  output logic              metric_clr_o,
  input  logic [7:0]        surv_in_i,
  input  logic [2:0]        best_idx_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              dec_valid_o,
  output logic [2:0]        dec_state_o,
  input  logic              dec_ready_i,
  output logic              frame_done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACS, S_FLUSH, S_SEL, S_TB_RD, S_TB_OUT, S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sym_cnt_q, sym_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] tb_addr_q, tb_addr_d;
  logic [2:0]        cur_q, cur_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              rd_fresh_q, rd_fresh_d;
  logic [7:0]        rdata_eff;

  // Trellis predecessor of state s given survivor decision bit b.
  function automatic logic [2:0] pred(input logic [2:0] s, input logic b);
    logic [2:0] p;
    case (s)
      3'd0:    p = b ? 3'd1 : 3'd0;
      3'd1:    p = b ? 3'd2 : 3'd3;
      3'd2:    p = b ? 3'd5 : 3'd4;
      3'd3:    p = b ? 3'd6 : 3'd7;
      3'd4:    p = b ? 3'd0 : 3'd1;
      3'd5:    p = b ? 3'd3 : 3'd2;
      3'd6:    p = b ? 3'd4 : 3'd5;
      default: p = b ? 3'd7 : 3'd6;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      sym_cnt_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      tb_addr_q  <= '0;
      cur_q      <= '0;
      rdata_q    <= '0;
      rd_fresh_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      tb_addr_q  <= tb_addr_d;
      cur_q      <= cur_d;
      rdata_q    <= rdata_d;
      rd_fresh_q <= rd_fresh_d;
    end
  end

  // RAM data is live only in the first TB_OUT cycle; afterwards use the captured copy.
  assign rdata_eff = rd_fresh_q ? mem_rdata_i : rdata_q;

  always_comb begin
    state_d       = state_q;
    sym_cnt_d     = sym_cnt_q;
    we_d          = 1'b0;
    waddr_d       = waddr_q;
    tb_addr_d     = tb_addr_q;
    cur_d         = cur_q;
    rdata_d       = rdata_q;
    rd_fresh_d    = 1'b0;
    busy_o        = (state_q != S_IDLE);
    sym_ready_o   = 1'b0;
    path_enable_o = 1'b0;
    metric_clr_o  = 1'b0;
    mem_re_o      = 1'b0;
    mem_raddr_o   = '0;
    dec_valid_o   = 1'b0;
    dec_state_o   = '0;
    frame_done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          metric_clr_o = 1'b1;
          sym_cnt_d    = '0;
          state_d      = S_ACS;
        end
      end
      S_ACS: begin
        sym_ready_o = 1'b1;
        if (sym_valid_i) begin
          path_enable_o = 1'b1;
          we_d          = 1'b1;
          waddr_d       = sym_cnt_q;
          if (sym_cnt_q == LAST) state_d = S_FLUSH;
          else                   sym_cnt_d = sym_cnt_q + ONE;
        end
      end
      S_FLUSH: state_d = S_SEL;
      S_SEL: begin
        cur_d     = best_idx_i;
        tb_addr_d = LAST;
        state_d   = S_TB_RD;
      end
      S_TB_RD: begin
        mem_re_o    = 1'b1;
        mem_raddr_o = tb_addr_q;
        rd_fresh_d  = 1'b1;
        state_d     = S_TB_OUT;
      end
      S_TB_OUT: begin
        dec_valid_o = 1'b1;
        dec_state_o = cur_q;
        if (rd_fresh_q) rdata_d = mem_rdata_i;
        if (dec_ready_i) begin
          cur_d = pred(cur_q, rdata_eff[cur_q]);
          if (tb_addr_q == '0) begin
            state_d = S_DONE;
          end else begin
            tb_addr_d = tb_addr_q - ONE;
            state_d   = S_TB_RD;
          end
        end
      end
      S_DONE: begin
        frame_done_o = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_we_o    = we_q;
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = we_q ? surv_in_i : 8'h00;

endmodule
